// File: rtl/uart_cmd_parser_if.sv
// Byte-strobe input side and decoded-command output side of the UART command parser.
interface uart_cmd_parser_if;
  logic       rxd_flag;
  logic [7:0] rxd_data;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       sum_err;
  logic       timeout_err;
  logic [7:0] err_cnt;
  logic       busy;

  // Upstream receiver plus downstream consumers.
  modport master (
    output rxd_flag, rxd_data,
    input  cmd_valid, cmd_code, cmd_addr, cmd_data,
    input  sum_err, timeout_err, err_cnt, busy
  );

  // The parser itself.
  modport slave (
    input  rxd_flag, rxd_data,
    output cmd_valid, cmd_code, cmd_addr, cmd_data,
    output sum_err, timeout_err, err_cnt, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte UART command frames (55 AA cmd addr data sum), validates the
// checksum, and flags inter-byte timeouts with header resynchronisation.
module uart_cmd_parser #(
  parameter logic [7:0]  HEAD0       = 8'h55,
  parameter logic [7:0]  HEAD1       = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned TO_W        = 20
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.slave   bus
);

  localparam int unsigned BYTE_W  = 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BYTE_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_H0,
    S_H1,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_SUM
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [BYTE_W-1:0] cmd_sh_q, cmd_sh_d;
  logic [BYTE_W-1:0] addr_sh_q, addr_sh_d;
  logic [BYTE_W-1:0] data_sh_q, data_sh_d;
  logic [BYTE_W-1:0] cmd_code_q, cmd_code_d;
  logic [BYTE_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [BYTE_W-1:0] cmd_data_q, cmd_data_d;
  logic [BYTE_W-1:0] err_cnt_q, err_cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              sum_err_q, sum_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] sum_c;

  assign sum_c = cmd_sh_q + addr_sh_q + data_sh_q;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_H0;
      to_cnt_q      <= '0;
      cmd_sh_q      <= '0;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      cmd_code_q    <= '0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      err_cnt_q     <= '0;
      cmd_valid_q   <= 1'b0;
      sum_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      cmd_sh_q      <= cmd_sh_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      cmd_code_q    <= cmd_code_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_data_q    <= cmd_data_d;
      err_cnt_q     <= err_cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      sum_err_q     <= sum_err_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, frame assembly and timeout supervision.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    cmd_sh_d      = cmd_sh_q;
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    cmd_code_d    = cmd_code_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_data_d    = cmd_data_q;
    err_cnt_d     = err_cnt_q;
    cmd_valid_d   = 1'b0;
    sum_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    if (bus.rxd_flag) begin
      to_cnt_d = '0;
      unique case (state_q)
        S_H0: begin
          if (bus.rxd_data == HEAD0) state_d = S_H1;
        end
        S_H1: begin
          // A repeated HEAD0 may be the true start of a frame.
          if (bus.rxd_data == HEAD1)      state_d = S_CMD;
          else if (bus.rxd_data == HEAD0) state_d = S_H1;
          else                            state_d = S_H0;
        end
        S_CMD: begin
          cmd_sh_d = bus.rxd_data;
          state_d  = S_ADDR;
        end
        S_ADDR: begin
          addr_sh_d = bus.rxd_data;
          state_d   = S_DATA;
        end
        S_DATA: begin
          data_sh_d = bus.rxd_data;
          state_d   = S_SUM;
        end
        S_SUM: begin
          state_d = S_H0;
          if (bus.rxd_data == sum_c) begin
            cmd_code_d  = cmd_sh_q;
            cmd_addr_d  = addr_sh_q;
            cmd_data_d  = data_sh_q;
            cmd_valid_d = 1'b1;
          end else begin
            sum_err_d = 1'b1;
          end
        end
        default: state_d = S_H0;
      endcase
    end else if (state_q != S_H0) begin
      if (to_cnt_q == TO_LAST) begin
        state_d       = S_H0;
        timeout_err_d = 1'b1;
        to_cnt_d      = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    if ((sum_err_d || timeout_err_d) && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + BYTE_W'(1);
    end

    busy_d = (state_d != S_H0);
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.sum_err     = sum_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised bench for uart_cmd_parser, checked every cycle against a
// frame-queue reference model.
module tb_uart_cmd_parser;

  localparam int unsigned TO_CYC = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .HEAD0       (8'h55),
    .HEAD1       (8'hAA),
    .TIMEOUT_CYC (TO_CYC),
    .TO_W        (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the frame collected so far, idle time, outputs.
  logic [7:0] frm[$];
  int         idle;
  logic       m_valid, m_serr, m_to;
  logic [7:0] m_code, m_addr, m_data;
  int         m_errs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    frm.delete();
    idle = 0;
    m_valid = 0; m_serr = 0; m_to = 0;
    m_code = 0; m_addr = 0; m_data = 0;
    m_errs = 0;
  endtask

  task automatic model_edge(input logic f, input logic [7:0] b);
    int s;
    m_valid = 0; m_serr = 0; m_to = 0;
    if (f) begin
      idle = 0;
      if (frm.size() == 0) begin
        if (b == 8'h55) frm.push_back(b);
      end else if (frm.size() == 1) begin
        if (b == 8'hAA) frm.push_back(b);
        else if (b != 8'h55) frm.delete();
      end else if (frm.size() < 5) begin
        frm.push_back(b);
      end else begin
        s = (int'(frm[2]) + int'(frm[3]) + int'(frm[4])) % 256;
        if (int'(b) == s) begin
          m_valid = 1; m_code = frm[2]; m_addr = frm[3]; m_data = frm[4];
        end else begin
          m_serr = 1;
        end
        frm.delete();
      end
    end else if (frm.size() > 0) begin
      idle++;
      if (idle == TO_CYC) begin
        m_to = 1; idle = 0; frm.delete();
      end
    end else begin
      idle = 0;
    end
    if (m_serr || m_to) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".cmd_valid"},   32'(bus.cmd_valid),   32'(m_valid));
    check({ctx, ".sum_err"},     32'(bus.sum_err),     32'(m_serr));
    check({ctx, ".timeout_err"}, 32'(bus.timeout_err), 32'(m_to));
    check({ctx, ".busy"},        32'(bus.busy),        32'(frm.size() > 0));
    check({ctx, ".err_cnt"},     32'(bus.err_cnt),     32'(m_errs));
    check({ctx, ".cmd"},         {8'h0, bus.cmd_code, bus.cmd_addr, bus.cmd_data},
                                 {8'h0, m_code, m_addr, m_data});
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic step(input logic f, input logic [7:0] b);
    bus.rxd_flag = f;
    bus.rxd_data = f ? b : 8'($urandom);
    model_edge(f, b);
    @(posedge clk);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic bad, input int gap);
    logic [7:0] s;
    s = c + a + d;
    if (bad) s = s + 8'(1 + $urandom_range(0, 254));
    send_byte(8'h55, gap); send_byte(8'hAA, gap);
    send_byte(c, gap); send_byte(a, gap); send_byte(d, gap); send_byte(s, gap);
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i], $urandom_range(0, 2));
  endtask

  task automatic do_reset(input int cycles);
    bus.rxd_flag = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    repeat (cycles) @(negedge clk);
    compare_all("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq[$];
    bus.rxd_flag = 1'b0;
    bus.rxd_data = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset(2);
    step(1'b0, 8'h00);

    // Nominal and checksum-error frames.
    seq = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h47}; send_seq(seq);
    check("nominal.code", 32'(bus.cmd_code), 32'h01);
    seq = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h48}; send_seq(seq);
    check("badsum.errcnt", 32'(bus.err_cnt), 32'd1);
    seq = '{8'h55, 8'hAA, 8'h02, 8'h03, 8'h04, 8'h09}; send_seq(seq);
    check("good2.data", 32'(bus.cmd_data), 32'h04);

    // Resync on repeated header, wrapping sum, and broken header.
    seq = '{8'h55, 8'h55, 8'hAA, 8'hFF, 8'h80, 8'h81, 8'h00}; send_seq(seq);
    check("wrap.addr", 32'(bus.cmd_addr), 32'h80);
    seq = '{8'h55, 8'h13, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h06}; send_seq(seq);
    check("nohdr.code", 32'(bus.cmd_code), 32'hFF);

    // Timeout, then a byte landing exactly on the timeout edge.
    seq = '{8'h55, 8'hAA, 8'h01}; send_seq(seq);
    repeat (TO_CYC + 3) step(1'b0, 8'h00);
    check("to.errcnt", 32'(bus.err_cnt), 32'd2);
    seq = '{8'h55, 8'hAA, 8'h01}; send_seq(seq);
    send_byte(8'h02, TO_CYC - 1);
    send_byte(8'h03, TO_CYC - 1);
    send_byte(8'h06, 0);
    check("to_edge.valid_code", 32'(bus.cmd_code), 32'h01);
    send_frame(8'h21, 8'h22, 8'h23, 1'b0, 1);

    // Reset mid-frame.
    seq = '{8'h55, 8'hAA, 8'h01, 8'h12}; send_seq(seq);
    @(negedge clk);
    do_reset(3);
    step(1'b0, 8'h00);
    seq = '{8'h55, 8'hAA, 8'h05, 8'h06, 8'h07, 8'h12}; send_seq(seq);
    check("after_rst.code", 32'(bus.cmd_code), 32'h05);

    // Random frames, noise and gaps, some straddling the timeout.
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5)       send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3));
      else if (kind < 7)  send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, $urandom_range(0, 3));
      else if (kind < 9)  send_byte(($urandom_range(0, 1) == 1) ? 8'h55 : 8'($urandom), $urandom_range(0, 3));
      else                send_byte(8'($urandom), $urandom_range(TO_CYC - 2, TO_CYC + 2));
    end

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
    check("sat.errcnt", 32'(bus.err_cnt), 32'd255);
    send_frame(8'h10, 8'h20, 8'h30, 1'b0, 0);
    check("sat.code", 32'(bus.cmd_code), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
